// File: rtl/fifo_stream_downsizer_if.sv
// FIFO read port plus narrow valid/ready beat stream seen by fifo_stream_downsizer.
// master = downsizer side, slave = FIFO/sink side.
interface fifo_stream_downsizer_if #(
   parameter int DATA_WITH = 16,
   parameter int OUT_WITH  = 8
);
   logic                 fifo_empty;
   logic [DATA_WITH-1:0] fifo_data;
   logic                 fifo_read;
   logic                 m_valid;
   logic                 m_ready;
   logic [OUT_WITH-1:0]  m_data;
   logic                 m_last;
   logic                 m_parity;

   modport master (
      input  fifo_empty, fifo_data, m_ready,
      output fifo_read, m_valid, m_data, m_last, m_parity
   );

   modport slave (
      output fifo_empty, fifo_data, m_ready,
      input  fifo_read, m_valid, m_data, m_last, m_parity
   );
endinterface

// File: rtl/fifo_stream_downsizer.sv
// Splits each FIFO word into DATA_WITH/OUT_WITH beats; first beat 2 cycles after fifo_read, LANES+1 cycles/word.
// Beats hold under m_ready backpressure; FIFO_STREAM_PARITY_EN adds even parity on m_parity.
module fifo_stream_downsizer #(
   parameter int DATA_WITH = 16,
   parameter int OUT_WITH  = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   fifo_stream_downsizer_if.master  io_bus,
   output logic                     o_busy
);

   localparam int LANES  = DATA_WITH / OUT_WITH;
   localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SEND = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [LANE_W-1:0]    r_lane;
   logic [LANE_W-1:0]    w_lane_nxt;
   logic [DATA_WITH-1:0] r_shift;
   logic                 w_read;
   logic                 w_load;
   logic                 w_shift_en;
   logic                 w_valid;
   logic                 w_hs;
   logic [OUT_WITH-1:0]  w_data;

   assign w_valid = (r_state == SEND);
   assign w_hs    = w_valid && io_bus.m_ready;

   // The outgoing lane always sits at the end selected by MSB_FIRST; shifting
   // after each accepted beat brings the next lane into place.
   assign w_data = MSB_FIRST ? r_shift[DATA_WITH-1 -: OUT_WITH] : r_shift[OUT_WITH-1:0];

   always_comb begin
      w_state_nxt = r_state;
      w_lane_nxt  = r_lane;
      w_read      = 1'b0;
      w_load      = 1'b0;
      w_shift_en  = 1'b0;
      case (r_state)
         IDLE: begin
            if (!io_bus.fifo_empty) begin
               w_read      = 1'b1;
               w_state_nxt = LOAD;
            end
         end
         LOAD: begin
            w_load      = 1'b1;
            w_lane_nxt  = '0;
            w_state_nxt = SEND;
         end
         SEND: begin
            if (w_hs) begin
               if (r_lane == LAST_LANE) begin
                  if (!io_bus.fifo_empty) begin
                     w_read      = 1'b1;
                     w_state_nxt = LOAD;
                  end else begin
                     w_state_nxt = IDLE;
                  end
               end else begin
                  w_lane_nxt = r_lane + LANE_W'(1);
                  w_shift_en = 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
         r_lane  <= '0;
         r_shift <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_lane  <= w_lane_nxt;
         if (w_load) begin
            r_shift <= io_bus.fifo_data;
         end else if (w_shift_en) begin
            r_shift <= MSB_FIRST ? (r_shift << OUT_WITH) : (r_shift >> OUT_WITH);
         end
      end
   end

   // Read request is combinational from IDLE, so it must be masked while reset is held.
   assign io_bus.fifo_read = w_read && i_rst_n;
   assign io_bus.m_valid   = w_valid;
   assign io_bus.m_data    = w_data;
   assign io_bus.m_last    = w_valid && (r_lane == LAST_LANE);
   assign o_busy           = (r_state != IDLE);

`ifdef FIFO_STREAM_PARITY_EN
   assign io_bus.m_parity = w_valid && (^w_data);
`else
   assign io_bus.m_parity = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_stream_downsizer.sv
// Scoreboard bench: a queue-based FIFO model feeds two downsizers (MSB- and LSB-first);
// expected beats are queued when a word is read and checked by a negedge monitor.
module tb_fifo_stream_downsizer;

   localparam int DW    = 16;
   localparam int OW    = 8;
   localparam int LANES = DW / OW;

   typedef struct packed {
      logic [OW-1:0] d;
      logic          l;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          fifo_empty = 1'b1;
   logic [DW-1:0] fifo_data = '0;
   logic          m_ready = 1'b0;
   logic          busy0;
   logic          busy1;

   always #5 clk = ~clk;

   fifo_stream_downsizer_if #(.DATA_WITH(DW), .OUT_WITH(OW)) bus0 ();
   fifo_stream_downsizer_if #(.DATA_WITH(DW), .OUT_WITH(OW)) bus1 ();

   assign bus0.fifo_empty = fifo_empty;
   assign bus0.fifo_data  = fifo_data;
   assign bus0.m_ready    = m_ready;
   assign bus1.fifo_empty = fifo_empty;
   assign bus1.fifo_data  = fifo_data;
   assign bus1.m_ready    = m_ready;

   fifo_stream_downsizer #(.DATA_WITH(DW), .OUT_WITH(OW), .MSB_FIRST(1'b1)) u_msb (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .io_bus  (bus0),
      .o_busy  (busy0)
   );

   fifo_stream_downsizer #(.DATA_WITH(DW), .OUT_WITH(OW), .MSB_FIRST(1'b0)) u_lsb (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .io_bus  (bus1),
      .o_busy  (busy1)
   );

   logic [DW-1:0] fifo_q[$];
   beat_t         exp0[$];
   beat_t         exp1[$];
   int            rd_times[$];
   int            n_chk = 0;
   int            n_pass = 0;
   int            cyc = 0;
   int            rd_count = 0;
   int            rd_cyc = 0;
   bit            pending = 1'b0;
   bit            hold0 = 1'b0;
   logic [OW+1:0] hold_snap = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
   endtask

   function automatic logic exp_par(input logic [OW-1:0] d);
`ifdef FIFO_STREAM_PARITY_EN
      return ^d;
`else
      return 1'b0;
`endif
   endfunction

   // FIFO model: a read pops the head word, which appears on fifo_data the next cycle.
   // The word's beats in both lane orders become the expected stream.
   always @(posedge clk) begin : fifo_model
      logic [DW-1:0] w;
      if (bus0.fifo_read && fifo_q.size() > 0) begin
         w = fifo_q.pop_front();
         fifo_data <= w;
         for (int i = 0; i < LANES; i++) begin
            exp1.push_back('{d: w[i*OW +: OW], l: (i == LANES - 1)});
            exp0.push_back('{d: w[(LANES-1-i)*OW +: OW], l: (i == LANES - 1)});
         end
      end
      fifo_empty <= (fifo_q.size() == 0);
   end

   always @(negedge clk) begin : monitor
      beat_t e;
      cyc++;
      if (!rst_n) begin
         chk("reset_outputs",
             32'({bus0.m_valid, bus0.fifo_read, busy0, bus0.m_last, bus0.m_parity, bus0.m_data,
                  bus1.m_valid, bus1.fifo_read, busy1, bus1.m_last, bus1.m_parity}), 32'd0);
         exp0.delete();
         exp1.delete();
         pending = 1'b0;
         hold0   = 1'b0;
      end else begin
         chk("read_while_empty", 32'(bus0.fifo_read & fifo_empty), 32'd0);
         if (hold0)
            chk("backpressure_hold",
                32'({bus0.m_valid, bus0.m_last, bus0.m_parity, bus0.m_data}), 32'({1'b1, hold_snap}));
         if (pending && bus0.m_valid) begin
            chk("first_beat_latency", 32'(cyc - rd_cyc), 32'd2);
            pending = 1'b0;
         end
         if (!bus0.m_valid)
            chk("idle_last_parity", 32'({bus0.m_last, bus0.m_parity}), 32'd0);
         if (bus0.m_valid && m_ready) begin
            if (exp0.size() == 0) chk("msb_unexpected_beat", 32'd1, 32'd0);
            else begin
               e = exp0.pop_front();
               chk("msb_beat", 32'({bus0.m_data, bus0.m_last, bus0.m_parity}),
                   32'({e.d, e.l, exp_par(e.d)}));
            end
         end
         if (bus1.m_valid && m_ready) begin
            if (exp1.size() == 0) chk("lsb_unexpected_beat", 32'd1, 32'd0);
            else begin
               e = exp1.pop_front();
               chk("lsb_beat", 32'({bus1.m_data, bus1.m_last, bus1.m_parity}),
                   32'({e.d, e.l, exp_par(e.d)}));
            end
         end
         hold0     = bus0.m_valid && !m_ready;
         hold_snap = {bus0.m_last, bus0.m_parity, bus0.m_data};
         if (bus0.fifo_read) begin
            pending = 1'b1;
            rd_cyc  = cyc;
            rd_count++;
            rd_times.push_back(cyc);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while ((busy0 || fifo_q.size() != 0 || !fifo_empty) && n < 500) begin
         tick();
         n++;
      end
      tick();
      chk(name, 32'(n < 500), 32'd1);
      chk({name, "_drained"}, 32'(exp0.size() + exp1.size()), 32'd0);
   endtask

   initial begin : stim
      int rd0;
      int n;

      // Reset held 50 cycles, then idle with an empty FIFO.
      rst_n = 1'b0;
      repeat (50) tick();
      rst_n = 1'b1;
      repeat (5) tick();
      chk("idle_after_reset", 32'({bus0.fifo_read, bus0.m_valid, busy0}), 32'd0);

      // Single word, sink always ready.
      m_ready = 1'b1;
      rd0 = rd_count;
      fifo_q.push_back(16'hA55A);
      wait_idle("single_word");
      chk("single_word_reads", 32'(rd_count - rd0), 32'd1);

      // Backpressure on the first beat for 3 cycles.
      m_ready = 1'b0;
      rd0 = rd_count;
      fifo_q.push_back(16'hA55A);
      n = 0;
      while (!bus0.m_valid && n < 20) begin
         tick();
         n++;
      end
      chk("bp_valid_seen", 32'(bus0.m_valid), 32'd1);
      repeat (3) tick();
      chk("bp_held_data", 32'({bus0.m_valid, bus0.m_data}), 32'h1A5);
      m_ready = 1'b1;
      wait_idle("backpressure");
      chk("bp_reads", 32'(rd_count - rd0), 32'd1);

      // 32 back-to-back words, sink always ready: reads every 3 cycles.
      rd0 = rd_count;
      rd_times.delete();
      for (int i = 1; i <= 32; i++) fifo_q.push_back(DW'(i));
      wait_idle("burst32");
      chk("burst32_reads", 32'(rd_count - rd0), 32'd32);
      for (int i = 1; i < rd_times.size(); i++)
         chk("burst32_read_spacing", 32'(rd_times[i] - rd_times[i-1]), 32'd3);
      chk("burst32_busy", 32'(busy0), 32'd0);

      // Random words with random sink readiness.
      for (int i = 0; i < 400; i++) begin
         m_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 3) == 0 && fifo_q.size() < 4)
            fifo_q.push_back(DW'($urandom));
         tick();
      end
      m_ready = 1'b1;
      wait_idle("random");

      // Reset during the second beat of 16'h1234, then a fresh word.
      fifo_q.push_back(16'h1234);
      n = 0;
      while (!bus0.m_valid && n < 20) begin
         tick();
         n++;
      end
      tick();
      m_ready = 1'b0;
      tick();
      chk("mid_word_second_beat", 32'({bus0.m_valid, bus0.m_last, bus0.m_data}), 32'h334);
      rst_n = 1'b0;
      #1;
      chk("reset_drops_valid", 32'({bus0.m_valid, bus1.m_valid, busy0}), 32'd0);
      repeat (3) tick();
      rst_n = 1'b1;
      m_ready = 1'b1;
      tick();
      fifo_q.push_back(16'h0103);
      wait_idle("after_reset_word");

      chk("final_queues_empty", 32'(exp0.size() + exp1.size() + fifo_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1);
   end

endmodule
